message_receive: RTL and testbench
==================================

Name: message_receive

Overview:
- Receive-side counterpart of the digital-modulation message transmitter.
- Takes the demodulated serial bit level plus the frame-present flag, times each bit period, and samples each bit at mid-period.
- Checks the 4-bit preamble and delivers the 5-bit payload with a one-cycle ready pulse.
- Sits after the demodulator/comparator and before the display/message consumer logic.

Parameters:
- BIT_CYCLES, 1024: clocks per bit period. Must be even and >= 8.
- PREAMBLE, 4'b0101: expected first four bits on the line, MSB first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- rx_bit  in  1  demodulated serial bit level, MSB of frame first.
- rx_valid  in  1  frame present; high for the whole frame duration.
- msg_out  out  5  last correctly received payload; holds between frames.
- msg_ready  out  1  one-cycle pulse when msg_out is updated.
- frame_err  out  1  one-cycle pulse on preamble mismatch or early frame abort.
- busy  out  1  high while in RECV or WAIT_END.

Behaviour:
- Reset (rst=0, async): state=IDLE; counters, 9-bit shift register and msg_out all 0; msg_ready=0, frame_err=0, busy=0.
- Frame: 9 bits, MSB first = PREAMBLE[3:0] followed by payload[4:0].
- Timing reference: k=0 is the first rising edge at which IDLE samples rx_valid=1.
- Bit i (i=0..8) is sampled from rx_bit at edge k = i*BIT_CYCLES + BIT_CYCLES/2 and shifted into the register LSB, moving older bits toward the MSB.
- Counters:
  - bit-cycle counter, width $clog2(BIT_CYCLES), wraps 0..BIT_CYCLES-1;
  - bit index counter 0..8.
- States:
  - IDLE: busy=0. On rx_valid=1, go to RECV with the cycle counter treated as k=0.
  - RECV: busy=1. Count cycles and sample. After the bit-8 sample, on the next edge:
    - if sreg[8:5]==PREAMBLE: msg_out<=sreg[4:0], msg_ready=1 for exactly one cycle;
    - else: frame_err=1 for one cycle, msg_out unchanged;
    - go to WAIT_END.
  - rx_valid=0 in RECV at any cycle before the decision: frame_err pulse next cycle, return to IDLE, sampled bits discarded, msg_out unchanged.
  - WAIT_END: busy=1. Stay until rx_valid=0, then go to IDLE. A frame held high indefinitely yields exactly one decision.
- Latency: msg_ready asserts at edge k = 8*BIT_CYCLES + BIT_CYCLES/2 + 1.
- msg_ready and frame_err are never high in the same cycle.
- Simultaneous rx_valid fall and decision edge: the decision wins, then WAIT_END exits on the next cycle.
- Reset mid-frame aborts immediately; no pulse is produced.

Optional Feature:
- Macro: MAJORITY_VOTE_EN.
- Defined: each bit is the 2-of-3 majority of rx_bit sampled at offsets BIT_CYCLES/4, BIT_CYCLES/2 and 3*BIT_CYCLES/4 within the bit period. The shift happens at the 3/4 point, so latency becomes k = 8*BIT_CYCLES + 3*BIT_CYCLES/4 + 1.
- Undefined: single mid-bit sample as described above; vote logic absent.

Test Plan (BIT_CYCLES=16):
- Frame 0101_10110, clean levels, rx_valid high for 160 clocks -> msg_out=5'b10110; one msg_ready pulse at k=137; frame_err never asserted; busy low after rx_valid falls.
- Frame 0111_00001 -> frame_err pulse at k=137; msg_out keeps previous 5'b10110; no msg_ready.
- rx_valid drops during bit 5 (k=85) -> frame_err pulse at k=86; IDLE at k=86. Then frame 0101_01011 -> msg_out=5'b01011.
- rst=0 at k=70 mid-frame -> all outputs 0 immediately; no pulse. After release, a full frame 0101_11111 -> msg_out=5'b11111.
- rx_valid held high for 400 clocks with frame 0101_00110 -> exactly one msg_ready. Then low 5 clocks, high again with a new frame -> a second capture.
- MAJORITY_VOTE_EN defined: bit 7 is a 1 with a single-cycle 0 glitch at the mid-bit sample point, frame 0101_00010 -> msg_out=5'b00010. With the macro undefined, the same stimulus -> msg_out=5'b00000.

Source files
------------

// File: rtl/message_receive.sv
// Serial frame receiver: times bit periods, samples mid-bit, checks preamble, emits 5-bit payload.
// Optional MAJORITY_VOTE_EN: 2-of-3 vote over quarter/half/three-quarter samples per bit.
module message_receive #(
    parameter int         BIT_CYCLES = 1024,
    parameter logic [3:0] PREAMBLE   = 4'b0101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       rx_valid,
    output logic [4:0] msg_out,
    output logic       msg_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2);
`ifdef MAJORITY_VOTE_EN
    localparam logic [CW-1:0] QTR1 = CW'(BIT_CYCLES / 4);
    localparam logic [CW-1:0] QTR3 = CW'((3 * BIT_CYCLES) / 4);
    localparam logic [CW-1:0] SHIFT_AT = QTR3;
`else
    localparam logic [CW-1:0] SHIFT_AT = HALF;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    sreg_q, sreg_d;
    logic [4:0]    msg_q, msg_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          bit_in;

`ifdef MAJORITY_VOTE_EN
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        bit_in = (s1_q & s2_q) | (s1_q & rx_bit) | (s2_q & rx_bit);
    end
`else
    always_comb begin
        bit_in = rx_bit;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            msg_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MAJORITY_VOTE_EN
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            msg_q   <= msg_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef MAJORITY_VOTE_EN
            s1_q    <= s1_d;
            s2_q    <= s2_d;
`endif
        end
    end

    // The decision edge takes priority over a simultaneous rx_valid fall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) state_d = RECV;
            end
            RECV: begin
                if (done_q)         state_d = WAIT_END;
                else if (!rx_valid) state_d = IDLE;
            end
            WAIT_END: begin
                if (!rx_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        msg_d   = msg_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        done_d  = done_q;
`ifdef MAJORITY_VOTE_EN
        s1_d    = s1_q;
        s2_d    = s2_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    // The accepting edge is k=0, so the next edge is k=1.
                    cnt_d  = CW'(1);
                    idx_d  = '0;
                    sreg_d = '0;
                    done_d = 1'b0;
                end
            end
            RECV: begin
                if (done_q) begin
                    done_d = 1'b0;
                    if (sreg_q[8:5] == PREAMBLE) begin
                        msg_d   = sreg_q[4:0];
                        ready_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!rx_valid) begin
                    err_d  = 1'b1;
                    cnt_d  = '0;
                    idx_d  = '0;
                    sreg_d = '0;
                end else begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
`ifdef MAJORITY_VOTE_EN
                    if (cnt_q == QTR1) s1_d = rx_bit;
                    if (cnt_q == HALF) s2_d = rx_bit;
`endif
                    if (cnt_q == SHIFT_AT) begin
                        sreg_d = {sreg_q[7:0], bit_in};
                        idx_d  = idx_q + 4'd1;
                        if (idx_q == 4'd8) done_d = 1'b1;
                    end
                end
            end
            WAIT_END: begin
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == RECV) || (state_q == WAIT_END);
        msg_out   = msg_q;
        msg_ready = ready_q;
        frame_err = err_q;
    end

endmodule

// File: tb/tb_message_receive.sv
// Scoreboard bench for message_receive with BIT_CYCLES=16.
// Stimulus queues expected pulses; a negedge monitor pops and compares them.
module tb_message_receive;

    localparam int BC = 16;
`ifdef MAJORITY_VOTE_EN
    localparam int DEC_K = 8 * BC + (3 * BC) / 4 + 1;
    localparam logic [4:0] VOTE_MSG = 5'b00010;
`else
    localparam int DEC_K = 8 * BC + BC / 2 + 1;
    localparam logic [4:0] VOTE_MSG = 5'b00000;
`endif

    logic       clk;
    logic       rst;
    logic       rx_bit;
    logic       rx_valid;
    logic [4:0] msg_out;
    logic       msg_ready;
    logic       frame_err;
    logic       busy;

    message_receive #(.BIT_CYCLES(BC), .PREAMBLE(4'b0101)) dut (
        .clk(clk),
        .rst(rst),
        .rx_bit(rx_bit),
        .rx_valid(rx_valid),
        .msg_out(msg_out),
        .msg_ready(msg_ready),
        .frame_err(frame_err),
        .busy(busy)
    );

    typedef struct {
        bit         is_err;
        logic [4:0] msg;
        int         edge_n;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (msg_ready || frame_err)) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: ready=%0b err=%0b at edge %0d, want none",
                             msg_ready, frame_err, cyc);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {30'd0, msg_ready, frame_err},
                          e.is_err ? 32'd1 : 32'd2);
                    check("pulse_edge", cyc, e.edge_n);
                    check("pulse_msg", {27'd0, msg_out}, {27'd0, e.msg});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge; the next edge is k=0 of the frame.
    task automatic run_frame(input logic [8:0] f, input int len, input int glitch_k,
                             input bit rst_abort, input bit exp_ev,
                             input bit is_err, input logic [4:0] msg, input int ev_k);
        exp_t e;
        if (exp_ev) begin
            e.is_err = is_err;
            e.msg = msg;
            e.edge_n = cyc + 1 + ev_k;
            q.push_back(e);
        end
        for (int k = 0; k < len; k++) begin
            rx_valid = 1'b1;
            rx_bit = (k / BC < 9) ? f[8 - k / BC] : 1'b0;
            if (k == glitch_k) rx_bit = 1'b0;
            @(posedge clk);
            #1;
        end
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        if (rst_abort) rst = 1'b0;
        rx_valid = 1'b0;
        rx_bit = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        rx_bit = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_msg_out", {27'd0, msg_out}, 32'd0);
        check("rst_ready", {31'd0, msg_ready}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        gap(3);

        run_frame(9'b0101_10110, 160, -1, 0, 1, 0, 5'b10110, DEC_K);
        gap(3);
        check("f1_busy_low", {31'd0, busy}, 32'd0);
        check("f1_msg", {27'd0, msg_out}, {27'd0, 5'b10110});

        run_frame(9'b0111_00001, 160, -1, 0, 1, 1, 5'b10110, DEC_K);
        gap(3);
        check("bad_pre_msg_held", {27'd0, msg_out}, {27'd0, 5'b10110});

        run_frame(9'b0101_01011, 86, -1, 0, 1, 1, 5'b10110, 86);
        gap(1);
        check("abort_idle", {31'd0, busy}, 32'd0);
        gap(2);
        run_frame(9'b0101_01011, 160, -1, 0, 1, 0, 5'b01011, DEC_K);
        gap(3);

        run_frame(9'b0101_11111, 70, -1, 1, 0, 0, 5'b00000, 0);
        #2;
        check("midrst_msg", {27'd0, msg_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, msg_ready}, 32'd0);
        check("midrst_err", {31'd0, frame_err}, 32'd0);
        gap(2);
        rst = 1'b1;
        gap(2);
        run_frame(9'b0101_11111, 160, -1, 0, 1, 0, 5'b11111, DEC_K);
        gap(3);

        run_frame(9'b0101_00110, 400, -1, 0, 1, 0, 5'b00110, DEC_K);
        gap(5);
        run_frame(9'b0101_10001, 160, -1, 0, 1, 0, 5'b10001, DEC_K);
        gap(3);

        run_frame(9'b0101_10101, DEC_K, -1, 0, 1, 0, 5'b10101, DEC_K);
        gap(1);
        check("tie_wait_end", {31'd0, busy}, 32'd1);
        gap(1);
        check("tie_idle", {31'd0, busy}, 32'd0);
        gap(2);

        run_frame(9'b0101_00010, 160, 7 * BC + BC / 2, 0, 1, 0, VOTE_MSG, DEC_K);
        gap(5);
        check("vote_msg", {27'd0, msg_out}, {27'd0, VOTE_MSG});

        check("queue_drained", q.size(), 32'd0);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            $display("FAIL missing_pulse: got none, want err=%0b msg=%b at edge %0d",
                     e.is_err, e.msg, e.edge_n);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
